// File: rtl/bank_sram_butterfly_read_if_pkg.sv
// Shared RemapCache parameters and types for the bank SRAM butterfly interfaces.
package bank_sram_butterfly_read_if_pkg;

    localparam int BW       = 8;   // bits per bank word
    localparam int NDATA    = 32;  // hiaddr range
    localparam int NBANK    = 16;  // banks / lanes, power of 2
    localparam int XOR_BW   = 4;   // selectable hiaddr bits per stage
    localparam int ABW      = 6;   // bank-local address width
    localparam int SRAM_LAT = 1;   // fixed SRAM read latency

    localparam int CLOG2_NDATA  = $clog2(NDATA);
    localparam int CLOG2_NBANK  = $clog2(NBANK);
    localparam int CLOG2_XOR_BW = $clog2(XOR_BW);
    localparam int HI_IW        = $clog2(CLOG2_NDATA);

    // Output FIFO: one slot per command that can be in the SRAM plus one.
    localparam int FIFO_D = SRAM_LAT + 1;
    localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CNT_W  = $clog2(FIFO_D + 1);

    typedef logic [CLOG2_NBANK-1:0] bf_ctl_t;
    typedef logic [NBANK-1:0][BW-1:0] bank_vec_t;

    // Modulo-D pointer advance; D need not be a power of 2.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/bank_butterfly_permute.sv
// XOR butterfly lane permutation: o_data[k] = i_data[k ^ i_m].
// Self-inverse, so the same block serves the write and the read side.
module bank_butterfly_permute
    import bank_sram_butterfly_read_if_pkg::*;
(
    input  logic [CLOG2_NBANK-1:0]   i_m,
    input  logic [NBANK-1:0][BW-1:0] i_data,
    output logic [NBANK-1:0][BW-1:0] o_data
);

    // each logical lane picks the bank its XOR control points at
    for (genvar k = 0; k < NBANK; k++) begin : g_lane
        assign o_data[k] = i_data[CLOG2_NBANK'(k) ^ i_m];
    end

endmodule

// File: rtl/bank_sram_butterfly_read_if.sv
// Read side of the bank SRAM butterfly: issues shared-address reads, carries
// each command's XOR control alongside the SRAM latency, un-permutes the
// returned banks and buffers them in a credit-guarded FIFO.
module bank_sram_butterfly_read_if
    import bank_sram_butterfly_read_if_pkg::*;
(
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic [CLOG2_NBANK-1:0]                    i_xor_mask,
    input  logic [CLOG2_NBANK-1:0][CLOG2_XOR_BW-1:0]  i_xor_scheme,
    input  logic                                      i_rdy,
    output logic                                      o_ack,
    input  logic [CLOG2_NDATA-1:0]                    i_hiaddr,
    input  logic [ABW-1:0]                            i_addr,
    output logic                                      o_sram_re,
    output logic [ABW-1:0]                            o_sram_addr,
    input  logic [NBANK-1:0][BW-1:0]                  i_sram_rdata,
    output logic                                      o_rdy,
    input  logic                                      i_ack,
    output logic [NBANK-1:0][BW-1:0]                  o_data
);

    logic                   accept;
    bf_ctl_t                m_acc;
    logic [SRAM_LAT:1]      vld_pipe;
    bf_ctl_t [SRAM_LAT:1]   m_pipe;
    bank_vec_t              tail_data;
    bank_vec_t              fifo_mem [FIFO_D];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       credit;
    logic                   push, pop;

    // A command is taken only when a FIFO slot is reserved for its data.
    // Credits return one cycle after the pop, so the loop sustains D commands
    // per D+1 cycles.
    assign accept      = i_rdy && (credit != '0) && !i_rst;
    assign o_ack       = accept;
    assign o_sram_re   = accept;
    assign o_sram_addr = i_addr;

    // per-stage XOR control from the hiaddr bit each stage selects
    always_comb begin
        m_acc = '0;
        for (int i = 0; i < CLOG2_NBANK; i++)
            m_acc[i] = i_xor_mask[i] & i_hiaddr[HI_IW'(i_xor_scheme[i])];
    end

    // valid half of the control pipe; matches the SRAM latency, never stalls
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= accept;
            for (int s = 2; s <= SRAM_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    // XOR control half of the pipe; qualified by vld_pipe, so no reset
    always_ff @(posedge i_clk) begin
        m_pipe[1] <= m_acc;
        for (int s = 2; s <= SRAM_LAT; s++) m_pipe[s] <= m_pipe[s-1];
    end

    bank_butterfly_permute u_permute (
        .i_m    (m_pipe[SRAM_LAT]),
        .i_data (i_sram_rdata),
        .o_data (tail_data)
    );

    assign push = vld_pipe[SRAM_LAT];
    assign pop  = o_rdy && i_ack;

    // FIFO storage; no bypass, so a push shows on o_rdy next cycle
    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr] <= tail_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // credits: one per FIFO slot, held from accept until the entry pops
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            credit <= CNT_W'(FIFO_D);
        end else if (accept && !pop) begin
            credit <= credit - CNT_W'(1);
        end else if (pop && !accept) begin
            credit <= credit + CNT_W'(1);
        end
    end

    assign o_rdy  = (count != '0);
    assign o_data = fifo_mem[rd_ptr];

    // the credit loop must leave room for every tail push
    assert property (@(posedge i_clk) disable iff (i_rst)
        !(push && (count == CNT_W'(FIFO_D))));

endmodule
